// File: rtl/axi4lite_regbank_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : axi4lite_regbank_pkg
//  Description : Shared response codes, state encodings and helper functions
//                for the AXI4-Lite register bank.
//  Revision    : 1.0 - initial release
// ============================================================================
package axi4lite_regbank_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {
        W_IDLE = 1'b0,
        W_RESP = 1'b1
    } wr_state_t;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rd_state_t;

    // Ceiling log2, usable in constant expressions.
    function automatic int clog2(input int value);
        int result = 0;
        int v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

    // Byte-lane merge at the widest supported bus (64 bits); narrower
    // callers zero-extend their operands and keep the low bits.
    function automatic logic [63:0] strobe_merge(input logic [63:0] old_val,
                                                 input logic [63:0] new_val,
                                                 input logic [7:0]  strb);
        logic [63:0] merged;
        merged = old_val;
        for (int k = 0; k < 8; k++) begin
            if (strb[k]) merged[k*8 +: 8] = new_val[k*8 +: 8];
        end
        return merged;
    endfunction

endpackage
`default_nettype wire

// File: rtl/axi4lite_hold_slot.sv
`default_nettype none
// ============================================================================
//  Module      : axi4lite_hold_slot
//  Description : One-entry valid/data holding slot with registered ready.
//                'have' and 'data' bypass the incoming beat so a consumer can
//                act in the same cycle as the handshake.
//  Ports       : clk, rst_n        - clock, async active-low reset
//                in_valid/in_data  - upstream channel
//                in_ready          - registered ready to upstream
//                clear             - consumer takes the slot content this cycle
//                block_next        - keep ready low next cycle (response busy)
//                have/data         - slot occupancy (incl. bypass) and content
//  Revision    : 1.0 - initial release
// ============================================================================
module axi4lite_hold_slot #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    input  logic             clear,
    input  logic             block_next,
    output logic             have,
    output logic [WIDTH-1:0] data
);

    logic             full;
    logic             full_next;
    logic             accept;
    logic [WIDTH-1:0] held;

    assign accept    = in_valid & in_ready;
    assign have      = full | accept;
    assign data      = full ? held : in_data;
    assign full_next = clear ? 1'b0 : have;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full     <= 1'b0;
            held     <= '0;
            in_ready <= 1'b0;
        end else begin
            full     <= full_next;
            if (accept) held <= in_data;
            // Ready is registered, so it reflects next-cycle occupancy.
            in_ready <= ~full_next & ~block_next;
        end
    end

endmodule
`default_nettype wire

// File: rtl/axi4lite_regbank.sv
`default_nettype none
// ============================================================================
//  Module      : axi4lite_regbank
//  Description : Parametrised AXI4-Lite slave register bank with byte strobes,
//                read-only status registers, SLVERR decode, independent AW/W
//                acceptance and per-register write/read pulses.
//  Ports       : ACLK/ARESETN   - clock, async active-low reset
//                S_AXI_*        - AXI4-Lite slave (AWPROT/ARPROT ignored)
//                reg_out        - flattened RW register contents
//                reg_in         - flattened status inputs for RO registers
//                wr_pulse       - one-cycle pulse on committed write
//                rd_pulse       - one-cycle pulse on in-range read
//  Revision    : 1.0 - initial release
// ============================================================================
module axi4lite_regbank
    import axi4lite_regbank_pkg::*;
#(
    parameter int                    C_DATA_WIDTH = 32,
    parameter int                    C_ADDR_WIDTH = 6,
    parameter int                    C_NUM_REGS   = 4,
    parameter logic [C_NUM_REGS-1:0] C_RO_MASK    = '0
) (
    input  logic                                ACLK,
    input  logic                                ARESETN,
    input  logic [C_ADDR_WIDTH-1:0]             S_AXI_AWADDR,
    input  logic [2:0]                          S_AXI_AWPROT,
    input  logic                                S_AXI_AWVALID,
    output logic                                S_AXI_AWREADY,
    input  logic [C_DATA_WIDTH-1:0]             S_AXI_WDATA,
    input  logic [C_DATA_WIDTH/8-1:0]           S_AXI_WSTRB,
    input  logic                                S_AXI_WVALID,
    output logic                                S_AXI_WREADY,
    output logic [1:0]                          S_AXI_BRESP,
    output logic                                S_AXI_BVALID,
    input  logic                                S_AXI_BREADY,
    input  logic [C_ADDR_WIDTH-1:0]             S_AXI_ARADDR,
    input  logic [2:0]                          S_AXI_ARPROT,
    input  logic                                S_AXI_ARVALID,
    output logic                                S_AXI_ARREADY,
    output logic [C_DATA_WIDTH-1:0]             S_AXI_RDATA,
    output logic [1:0]                          S_AXI_RRESP,
    output logic                                S_AXI_RVALID,
    input  logic                                S_AXI_RREADY,
    output logic [C_NUM_REGS*C_DATA_WIDTH-1:0]  reg_out,
    input  logic [C_NUM_REGS*C_DATA_WIDTH-1:0]  reg_in,
    output logic [C_NUM_REGS-1:0]               wr_pulse,
    output logic [C_NUM_REGS-1:0]               rd_pulse
);

    localparam int STRB_W   = C_DATA_WIDTH / 8;
    localparam int ADDR_LSB = clog2(STRB_W);
    localparam int IDX_W    = C_ADDR_WIDTH - ADDR_LSB;
    localparam int W_SLOT_W = C_DATA_WIDTH + STRB_W;

    wr_state_t                 wr_state;
    rd_state_t                 rd_state;
    logic [C_DATA_WIDTH-1:0]   regs [C_NUM_REGS];

    logic                      aw_have;
    logic [C_ADDR_WIDTH-1:0]   aw_addr;
    logic                      w_have;
    logic [W_SLOT_W-1:0]       w_bundle;
    logic [C_DATA_WIDTH-1:0]   wdata;
    logic [STRB_W-1:0]         wstrb;
    logic                      commit;
    logic                      bvalid_next;

    logic [IDX_W-1:0]          wr_idx;
    logic [IDX_W-1:0]          rd_idx;
    logic [C_NUM_REGS-1:0]     wr_hit;
    logic [C_NUM_REGS-1:0]     rd_hit;
    logic                      wr_ok;
    logic                      rd_ok;
    logic                      ar_hs;
    logic [C_DATA_WIDTH-1:0]   rd_mux;
    logic [C_DATA_WIDTH-1:0]   merged [C_NUM_REGS];

    // Commit fires in the same cycle both beats are available, so AW+W
    // together give BVALID on the following cycle.
    assign commit      = aw_have & w_have & (wr_state == W_IDLE);
    assign bvalid_next = commit | (S_AXI_BVALID & ~S_AXI_BREADY);

    axi4lite_hold_slot #(.WIDTH(C_ADDR_WIDTH)) u_aw_slot (
        .clk        (ACLK),
        .rst_n      (ARESETN),
        .in_valid   (S_AXI_AWVALID),
        .in_data    (S_AXI_AWADDR),
        .in_ready   (S_AXI_AWREADY),
        .clear      (commit),
        .block_next (bvalid_next),
        .have       (aw_have),
        .data       (aw_addr)
    );

    axi4lite_hold_slot #(.WIDTH(W_SLOT_W)) u_w_slot (
        .clk        (ACLK),
        .rst_n      (ARESETN),
        .in_valid   (S_AXI_WVALID),
        .in_data    ({S_AXI_WSTRB, S_AXI_WDATA}),
        .in_ready   (S_AXI_WREADY),
        .clear      (commit),
        .block_next (bvalid_next),
        .have       (w_have),
        .data       (w_bundle)
    );

    assign {wstrb, wdata} = w_bundle;
    assign wr_idx = aw_addr[C_ADDR_WIDTH-1:ADDR_LSB];
    assign rd_idx = S_AXI_ARADDR[C_ADDR_WIDTH-1:ADDR_LSB];
    assign ar_hs  = S_AXI_ARVALID & S_AXI_ARREADY;

    // One-hot decode; an all-zero hit vector means out of range.
    always_comb begin
        wr_hit = '0;
        rd_hit = '0;
        for (int i = 0; i < C_NUM_REGS; i++) begin
            wr_hit[i] = (wr_idx == IDX_W'(i));
            rd_hit[i] = (rd_idx == IDX_W'(i));
        end
    end

    assign wr_ok = |(wr_hit & ~C_RO_MASK);
    assign rd_ok = |rd_hit;

    always_comb begin
        logic [63:0] old64;
        logic [63:0] new64;
        logic [63:0] res64;
        logic [7:0]  strb8;
        new64 = '0;
        strb8 = '0;
        new64[C_DATA_WIDTH-1:0] = wdata;
        strb8[STRB_W-1:0]       = wstrb;
        for (int i = 0; i < C_NUM_REGS; i++) begin
            old64 = '0;
            old64[C_DATA_WIDTH-1:0] = regs[i];
            res64     = strobe_merge(old64, new64, strb8);
            merged[i] = res64[C_DATA_WIDTH-1:0];
        end
    end

    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < C_NUM_REGS; i++) begin
            if (rd_hit[i]) begin
                rd_mux = C_RO_MASK[i] ? reg_in[i*C_DATA_WIDTH +: C_DATA_WIDTH] : regs[i];
            end
        end
    end

    // Write response FSM and register storage.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            wr_state     <= W_IDLE;
            S_AXI_BVALID <= 1'b0;
            S_AXI_BRESP  <= RESP_OKAY;
            wr_pulse     <= '0;
            for (int i = 0; i < C_NUM_REGS; i++) regs[i] <= '0;
        end else begin
            wr_pulse <= '0;
            case (wr_state)
                W_IDLE: begin
                    if (commit) begin
                        wr_state     <= W_RESP;
                        S_AXI_BVALID <= 1'b1;
                        if (wr_ok) begin
                            S_AXI_BRESP <= RESP_OKAY;
                            wr_pulse    <= wr_hit & ~C_RO_MASK;
                            for (int i = 0; i < C_NUM_REGS; i++) begin
                                if (wr_hit[i] && !C_RO_MASK[i]) regs[i] <= merged[i];
                            end
                        end else begin
                            S_AXI_BRESP <= RESP_SLVERR;
                        end
                    end
                end
                W_RESP: begin
                    if (S_AXI_BREADY) begin
                        wr_state     <= W_IDLE;
                        S_AXI_BVALID <= 1'b0;
                    end
                end
                default: wr_state <= W_IDLE;
            endcase
        end
    end

    // Read FSM; ARREADY is registered and mirrors "no read response pending".
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            rd_state      <= R_IDLE;
            S_AXI_ARREADY <= 1'b0;
            S_AXI_RVALID  <= 1'b0;
            S_AXI_RDATA   <= '0;
            S_AXI_RRESP   <= RESP_OKAY;
            rd_pulse      <= '0;
        end else begin
            rd_pulse <= '0;
            case (rd_state)
                R_IDLE: begin
                    if (ar_hs) begin
                        rd_state      <= R_DATA;
                        S_AXI_ARREADY <= 1'b0;
                        S_AXI_RVALID  <= 1'b1;
                        S_AXI_RDATA   <= rd_mux;
                        S_AXI_RRESP   <= rd_ok ? RESP_OKAY : RESP_SLVERR;
                        rd_pulse      <= rd_hit;
                    end else begin
                        S_AXI_ARREADY <= 1'b1;
                    end
                end
                R_DATA: begin
                    if (S_AXI_RREADY) begin
                        rd_state      <= R_IDLE;
                        S_AXI_RVALID  <= 1'b0;
                        S_AXI_ARREADY <= 1'b1;
                    end
                end
                default: rd_state <= R_IDLE;
            endcase
        end
    end

    for (genvar gi = 0; gi < C_NUM_REGS; gi++) begin : g_reg_out
        assign reg_out[gi*C_DATA_WIDTH +: C_DATA_WIDTH] = regs[gi];
    end

    logic unused_bits;
    assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                           aw_addr[ADDR_LSB-1:0], S_AXI_ARADDR[ADDR_LSB-1:0]};

endmodule
`default_nettype wire

// File: doc/axi4lite_regbank.md
# axi4lite_regbank

Parametrised AXI4-Lite slave register bank: the next generation of the fixed four-register slave IP in our IP repository. It adds the following features:
- Configurable register count and data width.
- Byte-strobe writes.
- Per-register read-only status inputs.
- SLVERR decoding.
- Independent AW/W acceptance.
- Per-register write and read pulses for fabric logic.

It sits behind the PS/interconnect master on the control bus of each custom IP.

## Interface
- C_DATA_WIDTH, 32, bus/register width; 32 or 64 only
- C_ADDR_WIDTH, 6, AXI address width; must satisfy 2^C_ADDR_WIDTH ≥ C_NUM_REGS·C_DATA_WIDTH/8
- C_NUM_REGS, 4, number of registers, 1..256
- C_RO_MASK, 0, C_NUM_REGS-bit mask; bit i=1 makes register i read-only (reads come from reg_in)
- ACLK  in  1  clock
- ARESETN  in  1  asynchronous, active-low reset
- S_AXI_AWADDR/AWPROT/AWVALID  in  C_ADDR_WIDTH/3/1  write address channel (AWPROT ignored)
- S_AXI_AWREADY  out  1
- S_AXI_WDATA/WSTRB/WVALID  in  C_DATA_WIDTH/C_DATA_WIDTH/8/1  write data channel
- S_AXI_WREADY  out  1
- S_AXI_BRESP/BVALID  out  2/1;  S_AXI_BREADY  in  1
- S_AXI_ARADDR/ARPROT/ARVALID  in  C_ADDR_WIDTH/3/1  (ARPROT ignored);  S_AXI_ARREADY  out  1
- S_AXI_RDATA/RRESP/RVALID  out  C_DATA_WIDTH/2/1;  S_AXI_RREADY  in  1
- reg_out  out  C_NUM_REGS·C_DATA_WIDTH  flattened RW register contents, register i at bits [i·W +: W]
- reg_in  in  C_NUM_REGS·C_DATA_WIDTH  flattened status values; only used for RO registers
- wr_pulse  out  C_NUM_REGS  one-cycle pulse on successful write commit to register i
- rd_pulse  out  C_NUM_REGS  one-cycle pulse on successful read of register i (for clear-on-read fabric logic)

## Operation
- Register index is ADDR[C_ADDR_WIDTH-1 : log2(C_DATA_WIDTH/8)]. Address low bits are ignored.
- Write path:
  - AW and W are each captured into their own holding slot, independently and in either order.
  - AWREADY is 1 while the AW slot is empty and BVALID=0. WREADY follows the same rule for the W slot.
  - When both slots are full, the write commits on the next edge. Slots clear and BVALID rises.
  - Commit conditions: index < C_NUM_REGS and not RO. On commit, byte k is written where WSTRB[k]=1, BRESP=OKAY(00) and wr_pulse[index]=1.
  - Otherwise there is no state change, no pulse, and BRESP=SLVERR(10).
  - BVALID holds until BREADY.
- Read path:
  - ARREADY=1 when RVALID=0.
  - On an AR handshake, RDATA/RRESP are registered and RVALID rises the next cycle.
  - RDATA source: RO register → reg_in slice; RW register → reg_out slice.
  - An out-of-range index returns RDATA=0 and RRESP=SLVERR. rd_pulse fires only for in-range reads.
  - RVALID and RDATA hold stable until RREADY.
- Read/write fabric state machines:
  - Write: W_IDLE → W_RESP on commit; W_RESP → W_IDLE on BREADY.
  - Read: R_IDLE → R_DATA on AR handshake; R_DATA → R_IDLE on RREADY.
- A WSTRB of all zeros still returns OKAY and pulses wr_pulse, with data unchanged.

## Timing
- Reset (async assert, sync release):
  - All READY/VALID outputs go to 0. BRESP=RRESP=00, RDATA=0, all registers 0, pulses 0.
  - The READY outputs rise on the first edge after ARESETN goes high.
- Write latency: AW+W in the same cycle → BVALID next cycle. Best-case throughput is one write per 2 cycles.
- Read latency: AR handshake → RVALID next cycle. Best-case throughput is one read per 2 cycles.
- reg_out updates and wr_pulse assert on the same edge that raises BVALID.
- rd_pulse asserts on the same edge that raises RVALID.
- A read handshaking in the same cycle as a write commit to the same register returns the pre-write value.
- BREADY/RREADY held high before VALID rises: the response completes in the single VALID cycle.
- Reset mid-transaction: the pending transaction is dropped and BVALID/RVALID fall asynchronously. No partial write.

## Structure
- Shared package axi4lite_regbank_pkg holds:
  - localparams RESP_OKAY=2'b00 and RESP_SLVERR=2'b10.
  - typedefs for the write and read state enums.
  - function clog2 for index width.
- One sub-module, axi4lite_hold_slot: a parametrised-width valid/data holding register with ready generation. It is instantiated twice, for AW and for W.
- The strobe merge is a package function applying WSTRB to the old value and WDATA.

## Test plan
- Defaults (32-bit, 4 regs):
  - Write 0x1,0x2,0x3,0x4 to 0x0,0x4,0x8,0xC, then read back → RDATA matches, all BRESP/RRESP=00, wr_pulse/rd_pulse one cycle each.
- Strobe:
  - Write 0xFFFFFFFF to 0x0, then write 0x12345678 with WSTRB=0101 → read 0xFF34FF78.
- Channel ordering:
  - W presented 3 cycles before AW → WREADY high while AW is absent, a single commit, BVALID the cycle after the AW handshake.
- Error and RO (C_NUM_REGS=4, C_RO_MASK=4'b0010, reg_in slice 1=0xCAFEF00D):
  - Write to 0x4 → SLVERR, no wr_pulse.
  - Read 0x4 → 0xCAFEF00D with OKAY.
  - Read 0x10 → 0 with SLVERR.
- Backpressure/reset:
  - BREADY low for 5 cycles → AWREADY/WREADY stay 0 and BVALID stays stable.
  - ARESETN pulled low mid-response → BVALID drops immediately and all registers read 0 after release.
- 64-bit, 8 regs:
  - Write 0x0123456789ABCDEF to 0x38 → read back equal, reg_out[511:448] matches.
